mode_counter: RTL and testbench

Parametrised successor to the team's 8-bit load/enable counter.
- Adds configurable width, up/down direction and a programmable limit.
- Three modes: wrap, saturate, one-shot. One-shot is driven by a small FSM.
- Registered terminal-count pulse.
- Used as the general timer/event counter in control paths; one instance per channel at the top level.

---
 rtl/mode_counter_pkg.sv | 34 +++
 rtl/mode_counter_prescaler.sv | 37 +++
 rtl/mode_counter.sv | 159 +++++++++++++++
 tb/tb_mode_counter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_counter_pkg.sv
// Shared types and defaults for the mode_counter timer/event counter.
// Optional prescaler is enabled by defining MODE_COUNTER_PRESCALE_EN.
package mode_counter_pkg;

  // Counting mode as presented on the mode input; 2'b11 behaves as wrap.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  // One-shot sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } osh_state_t;

  localparam int unsigned DEFAULT_WIDTH      = 16;
  localparam int unsigned DEFAULT_PRESCALE_W = 8;

  // Fold the reserved encoding onto wrap so the datapath only sees three modes.
  function automatic mode_t eff_mode(input logic [1:0] m);
    mode_t r;
    case (m)
      2'b01:   r = MODE_SAT;
      2'b10:   r = MODE_ONESHOT;
      default: r = MODE_WRAP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mode_counter_prescaler.sv
// Tick generator for mode_counter: one tick every (prescale_i + 1) enabled
// cycles. Phase holds while enable_i is low and restarts on clr_i.
// Instantiated only when MODE_COUNTER_PRESCALE_EN is defined.
module mode_counter_prescaler
  import mode_counter_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  localparam logic [PRESCALE_W-1:0] PS_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] cnt_q;
  logic                  wrap_pt;

  // >= keeps the phase bounded if prescale_i is lowered mid-period.
  assign wrap_pt = (cnt_q >= prescale_i);
  assign tick_o  = enable_i && wrap_pt;

  // Phase counter: advance on enabled cycles, restart after each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= wrap_pt ? '0 : cnt_q + PS_ONE;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Parametrised up/down counter with wrap, saturate and one-shot modes and a
// registered single-cycle terminal-count pulse. Defining
// MODE_COUNTER_PRESCALE_EN adds a prescale input that divides the step rate.
// dbg_state_o exposes the one-shot sequencer state.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  up_dn,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  start,
`ifdef MODE_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state_o
);

  if (WIDTH < 2 || WIDTH > 32 || PRESCALE_W < 1) begin : g_bad_param
    $error("mode_counter: WIDTH must be 2..32 and PRESCALE_W at least 1");
  end

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             hold_q;   // last step left the count on T
  osh_state_t       state_q;
  logic             busy_q;
  logic             done_q;

  mode_t            mode_eff;
  logic             tick;
  logic             step;
  logic             at_term;
  logic             lands;
  logic             tc_step;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] next_val;

  assign mode_eff = eff_mode(mode);

`ifdef MODE_COUNTER_PRESCALE_EN
  // A load or clear restarts the prescaler phase as well as the count.
  mode_counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable),
    .clr_i      (clear || load),
    .prescale_i (prescale),
    .tick_o     (tick)
  );
`else
  assign tick = enable;
`endif

  // Step qualification, terminal detection and next count value.
  always_comb begin
    term_val = up_dn ? limit : '0;
    at_term  = up_dn ? (count_q >= limit) : (count_q == '0);
    step     = tick && ((mode_eff != MODE_ONESHOT) || (state_q == RUN));
    if (at_term) begin
      if (mode_eff == MODE_WRAP) next_val = up_dn ? '0 : limit;
      else                       next_val = count_q;
    end else begin
      next_val = up_dn ? (count_q + ONE) : (count_q - ONE);
    end
    lands   = (next_val == term_val);
    // Saturate suppresses repeat pulses while parked on T; one-shot leaves
    // RUN on the landing step so it can only pulse once per run.
    tc_step = step && lands && !((mode_eff == MODE_SAT) && hold_q);
  end

  // Count register and terminal-count pulse; clear beats load beats step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      hold_q  <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      hold_q  <= 1'b0;
    end else if (load) begin
      count_q <= load_val;
      tc_q    <= 1'b0;
      hold_q  <= 1'b0;
    end else if (step) begin
      count_q <= next_val;
      tc_q    <= tc_step;
      hold_q  <= lands;
    end else begin
      tc_q    <= 1'b0;
    end
  end

  // One-shot sequencer with registered busy/done; load freezes the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clear || (mode_eff != MODE_ONESHOT)) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!load) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (step && lands) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count       = count_q;
  assign tc          = tc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter at WIDTH = 8. Inputs change 1 ns after the
// rising edge; outputs are checked at that same point, after the edge settled.
module tb_mode_counter;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic       load;
  logic [7:0] load_val;
  logic       up_dn;
  logic [1:0] mode;
  logic [7:0] limit;
  logic       start;
`ifdef MODE_COUNTER_PRESCALE_EN
  logic [7:0] prescale;
`endif
  logic [7:0] count;
  logic       tc;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state_o;

  int checks;
  int failures;

  mode_counter #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clear       (clear),
    .load        (load),
    .load_val    (load_val),
    .up_dn       (up_dn),
    .mode        (mode),
    .limit       (limit),
    .start       (start),
`ifdef MODE_COUNTER_PRESCALE_EN
    .prescale    (prescale),
`endif
    .count       (count),
    .tc          (tc),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0; load_val = 8'h00;
    up_dn = 1'b1; mode = 2'b00; limit = 8'hFF; start = 1'b0;
`ifdef MODE_COUNTER_PRESCALE_EN
    prescale = 8'd0;
`endif
    #3;
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL reset_count got=%0h exp=0", count); end
    checks++; if (tc !== 1'b0)     begin failures++; $display("FAIL reset_tc got=%b exp=0", tc); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dbg_state_o !== 2'b00) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o); end
    tick_clk();
    rst_n = 1'b1;
    tick_clk();
  endtask

  task automatic test_load_hold();
    load = 1'b1; load_val = 8'hA5; enable = 1'b0;
    tick_clk();
    checks++; if (count !== 8'hA5) begin failures++; $display("FAIL load_count got=%0h exp=a5", count); end
    checks++; if (tc !== 1'b0)     begin failures++; $display("FAIL load_tc got=%b exp=0", tc); end
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_clk();
      checks++; if (count !== 8'hA5 || tc !== 1'b0) begin
        failures++; $display("FAIL hold_count[%0d] got=%0h tc=%b exp=a5 tc=0", i, count, tc);
      end
    end
    enable = 1'b1;
    tick_clk();
    checks++; if (count !== 8'hA6) begin failures++; $display("FAIL count_after_hold got=%0h exp=a6", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL async_reset_count got=%0h exp=0", count); end
    enable = 1'b0;
    tick_clk();
    rst_n = 1'b1;
    tick_clk();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_c [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    logic       exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    clear = 1'b1; mode = 2'b00; limit = 8'd5; up_dn = 1'b1;
    tick_clk();
    clear = 1'b0; enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick_clk();
      checks++; if (count !== exp_c[i]) begin failures++; $display("FAIL wrap_up_count[%0d] got=%0d exp=%0d", i, count, exp_c[i]); end
      checks++; if (tc !== exp_t[i])    begin failures++; $display("FAIL wrap_up_tc[%0d] got=%b exp=%b", i, tc, exp_t[i]); end
    end
    enable = 1'b0; load = 1'b1; load_val = 8'd1;
    tick_clk();
    load = 1'b0; up_dn = 1'b0; enable = 1'b1;
    tick_clk();
    checks++; if (count !== 8'd0 || tc !== 1'b1) begin failures++; $display("FAIL wrap_dn_zero got=%0d tc=%b exp=0 tc=1", count, tc); end
    tick_clk();
    checks++; if (count !== 8'd5 || tc !== 1'b0) begin failures++; $display("FAIL wrap_dn_reload got=%0d tc=%b exp=5 tc=0", count, tc); end
    enable = 1'b0; up_dn = 1'b1;
  endtask

  task automatic test_saturate();
    logic [7:0] exp_u [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    logic       exp_ut[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_d [4] = '{8'd2, 8'd1, 8'd0, 8'd0};
    logic       exp_dt[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    clear = 1'b1; mode = 2'b01; limit = 8'd3; up_dn = 1'b1;
    tick_clk();
    clear = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick_clk();
      checks++; if (count !== exp_u[i] || tc !== exp_ut[i]) begin
        failures++; $display("FAIL sat_up[%0d] got=%0d tc=%b exp=%0d tc=%b", i, count, tc, exp_u[i], exp_ut[i]);
      end
    end
    up_dn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      checks++; if (count !== exp_d[i] || tc !== exp_dt[i]) begin
        failures++; $display("FAIL sat_dn[%0d] got=%0d tc=%b exp=%0d tc=%b", i, count, tc, exp_d[i], exp_dt[i]);
      end
    end
    enable = 1'b0; up_dn = 1'b1;
  endtask

  task automatic test_oneshot();
    clear = 1'b1; mode = 2'b10; limit = 8'd4; up_dn = 1'b1;
    tick_clk();
    clear = 1'b0; enable = 1'b1;
    tick_clk();
    checks++; if (count !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL osh_idle got=%0d busy=%b exp=0 busy=0", count, busy); end
    start = 1'b1;
    tick_clk();
    checks++; if (busy !== 1'b1 || count !== 8'd0 || done !== 1'b0) begin
      failures++; $display("FAIL osh_start got busy=%b cnt=%0d done=%b exp busy=1 cnt=0 done=0", busy, count, done);
    end
    start = 1'b0;
    tick_clk();
    checks++; if (count !== 8'd1 || busy !== 1'b1) begin failures++; $display("FAIL osh_run1 got=%0d busy=%b exp=1 busy=1", count, busy); end
    start = 1'b1;
    tick_clk();
    checks++; if (count !== 8'd2 || busy !== 1'b1 || dbg_state_o !== 2'b01) begin
      failures++; $display("FAIL osh_restart_ignored got=%0d busy=%b st=%0d exp=2 busy=1 st=1", count, busy, dbg_state_o);
    end
    start = 1'b0;
    tick_clk();
    checks++; if (count !== 8'd3 || tc !== 1'b0) begin failures++; $display("FAIL osh_run3 got=%0d tc=%b exp=3 tc=0", count, tc); end
    tick_clk();
    checks++; if (count !== 8'd4 || tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL osh_term got=%0d tc=%b done=%b busy=%b exp=4 tc=1 done=1 busy=0", count, tc, done, busy);
    end
    tick_clk();
    checks++; if (count !== 8'd4 || tc !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL osh_hold got=%0d tc=%b done=%b exp=4 tc=0 done=1", count, tc, done);
    end
    clear = 1'b1;
    tick_clk();
    clear = 1'b0;
    checks++; if (count !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || dbg_state_o !== 2'b00) begin
      failures++; $display("FAIL osh_clear got=%0d done=%b busy=%b st=%0d exp=0 0 0 0", count, done, busy, dbg_state_o);
    end
    enable = 1'b0;
  endtask

  task automatic test_oneshot_at_term();
    mode = 2'b10; limit = 8'd2; up_dn = 1'b1; load = 1'b1; load_val = 8'd2;
    tick_clk();
    load = 1'b0; start = 1'b1;
    tick_clk();
    checks++; if (busy !== 1'b1 || dbg_state_o !== 2'b01) begin failures++; $display("FAIL osh_at_t_run busy=%b st=%0d exp busy=1 st=1", busy, dbg_state_o); end
    start = 1'b0; enable = 1'b1;
    tick_clk();
    checks++; if (count !== 8'd2 || tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL osh_at_t_done got=%0d tc=%b done=%b busy=%b exp=2 tc=1 done=1 busy=0", count, tc, done, busy);
    end
    enable = 1'b0; load = 1'b1; load_val = 8'd0;
    tick_clk();
    checks++; if (done !== 1'b1 || count !== 8'd0) begin failures++; $display("FAIL osh_load_keeps_done got=%0d done=%b exp=0 done=1", count, done); end
    load = 1'b0; start = 1'b1;
    tick_clk();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL osh_rerun busy=%b done=%b exp busy=1 done=0", busy, done); end
    start = 1'b0; mode = 2'b00;
    tick_clk();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || dbg_state_o !== 2'b00) begin
      failures++; $display("FAIL osh_mode_leave busy=%b done=%b st=%0d exp 0 0 0", busy, done, dbg_state_o);
    end
  endtask

  task automatic test_priority();
    mode = 2'b00; limit = 8'hFF; up_dn = 1'b1;
    clear = 1'b1; load = 1'b1; load_val = 8'h33; enable = 1'b1;
    tick_clk();
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL prio_clear got=%0h exp=0", count); end
    clear = 1'b0; limit = 8'h33;
    tick_clk();
    checks++; if (count !== 8'h33 || tc !== 1'b0) begin failures++; $display("FAIL prio_load got=%0h tc=%b exp=33 tc=0", count, tc); end
    load = 1'b0; enable = 1'b0;
    tick_clk();
  endtask

  task automatic test_limit_zero();
    logic exp_t [3] = '{1'b1, 1'b0, 1'b0};
    clear = 1'b1; mode = 2'b00; limit = 8'd0; up_dn = 1'b1;
    tick_clk();
    clear = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      checks++; if (count !== 8'd0 || tc !== 1'b1) begin failures++; $display("FAIL lim0_wrap[%0d] got=%0d tc=%b exp=0 tc=1", i, count, tc); end
    end
    clear = 1'b1; mode = 2'b01;
    tick_clk();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      checks++; if (count !== 8'd0 || tc !== exp_t[i]) begin failures++; $display("FAIL lim0_sat[%0d] got=%0d tc=%b exp=0 tc=%b", i, count, tc, exp_t[i]); end
    end
    enable = 1'b0;
  endtask

`ifdef MODE_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    logic       en_v  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_c [11] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};
    logic [7:0] exp_l [4]  = '{8'h10, 8'h10, 8'h10, 8'h11};
    prescale = 8'd2; mode = 2'b00; limit = 8'hFF; up_dn = 1'b1; clear = 1'b1;
    tick_clk();
    clear = 1'b0;
    for (int i = 0; i < 11; i++) begin
      enable = en_v[i];
      tick_clk();
      checks++; if (count !== exp_c[i]) begin failures++; $display("FAIL ps_count[%0d] got=%0d exp=%0d", i, count, exp_c[i]); end
    end
    enable = 1'b1;
    tick_clk();
    load = 1'b1; load_val = 8'h10;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      load = 1'b0;
      checks++; if (count !== exp_l[i]) begin failures++; $display("FAIL ps_load_phase[%0d] got=%0h exp=%0h", i, count, exp_l[i]); end
    end
    enable = 1'b0; prescale = 8'd0;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_load_hold();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_oneshot_at_term();
    test_priority();
    test_limit_zero();
`ifdef MODE_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
